// File: rtl/cellrv32_fetch_buffer.sv
// Front-end fetch engine: one-outstanding sequential i-cache requests feeding an
// instruction prefetch FIFO, with redirect flush and in-flight response discard.
module cellrv32_fetch_buffer #(
   parameter int unsigned IPB_DEPTH = 4,
   parameter logic [31:0] START_PC  = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        enable_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] cache_addr_o,
   output logic        cache_re_o,
   input  logic [31:0] cache_rdata_i,
   input  logic        cache_ack_i,
   input  logic        cache_err_i,
   output logic        ipb_valid_o,
   output logic [31:0] ipb_rdata_o,
   output logic [31:0] ipb_pc_o,
   output logic        ipb_err_o,
   input  logic        ipb_pop_i,
   output logic        busy_o
);

   localparam int unsigned AW = $clog2(IPB_DEPTH);
   localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
   localparam logic [AW:0] PTR_DEPTH = (AW+1)'(IPB_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_PEND, S_HALT, S_DRAIN} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [AW:0] rd_ptr, wr_ptr, cnt_post;
   logic [62:0] mem [IPB_DEPTH];
   logic [62:0] head;
   logic        full, empty, resp, push, pop, re;
   logic        unused_bits;

   assign unused_bits = ^redirect_pc_i[1:0];

   assign empty = (rd_ptr == wr_ptr);
   assign full  = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);
   assign resp  = cache_ack_i | cache_err_i;
   assign pop   = ipb_pop_i & ~empty & ~redirect_i;
   assign push  = (state == S_PEND) & resp & ~redirect_i;

   // Occupancy after this cycle's push and pop; decides a back-to-back request.
   assign cnt_post = (wr_ptr + PTR_ONE) - rd_ptr - (pop ? PTR_ONE : '0);

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      re        = 1'b0;
      if (redirect_i) begin
         pc_nxt    = {redirect_pc_i[31:2], 2'b00};
         state_nxt = ((state == S_PEND || state == S_DRAIN) && !resp) ? S_DRAIN : S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (enable_i && !full) begin
                  re        = 1'b1;
                  state_nxt = S_PEND;
               end
            end
            S_PEND: begin
               if (resp) begin
                  pc_nxt = pc + 32'd4;
                  if (cache_err_i) begin
                     state_nxt = S_HALT;
                  end else if (enable_i && (cnt_post != PTR_DEPTH)) begin
                     re = 1'b1;
                  end else begin
                     state_nxt = S_IDLE;
                  end
               end
            end
            S_DRAIN: begin
               if (resp) state_nxt = S_IDLE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state  <= S_IDLE;
         pc     <= {START_PC[31:2], 2'b00};
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         if (redirect_i) begin
            rd_ptr <= wr_ptr;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {cache_err_i, pc[31:2], cache_rdata_i};
   end

   assign head = mem[rd_ptr[AW-1:0]];

   // Request strobe masked during reset so every output reads zero while held.
   assign cache_re_o   = re & rstn_i;
   assign cache_addr_o = pc;
   assign busy_o       = (state == S_PEND) || (state == S_DRAIN);
   assign ipb_valid_o  = ~empty;
   assign ipb_rdata_o  = empty ? '0 : head[31:0];
   assign ipb_pc_o     = empty ? '0 : {head[61:32], 2'b00};
   assign ipb_err_o    = ~empty & head[62];

endmodule

// File: tb/tb_cellrv32_fetch_buffer.sv
// Bench for cellrv32_fetch_buffer: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_cellrv32_fetch_buffer;

   localparam int DEPTH = 4;

   logic        clk, rstn;
   logic        enable_i, redirect_i, ipb_pop_i;
   logic [31:0] redirect_pc_i, cache_rdata_i;
   logic        cache_ack_i, cache_err_i;
   logic [31:0] cache_addr_o, ipb_rdata_o, ipb_pc_o;
   logic        cache_re_o, ipb_valid_o, ipb_err_o, busy_o;

   cellrv32_fetch_buffer #(.IPB_DEPTH(DEPTH), .START_PC(32'h0000_0000)) dut (
      .clk_i(clk), .rstn_i(rstn), .enable_i(enable_i), .redirect_i(redirect_i),
      .redirect_pc_i(redirect_pc_i), .cache_addr_o(cache_addr_o), .cache_re_o(cache_re_o),
      .cache_rdata_i(cache_rdata_i), .cache_ack_i(cache_ack_i), .cache_err_i(cache_err_i),
      .ipb_valid_o(ipb_valid_o), .ipb_rdata_o(ipb_rdata_o), .ipb_pc_o(ipb_pc_o),
      .ipb_err_o(ipb_err_o), .ipb_pop_i(ipb_pop_i), .busy_o(busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endfunction

   // ---------------- directed vector table ----------------
   typedef struct {
      bit en, red; logic [31:0] rpc; bit pop, ack; logic [31:0] data;
      bit re; logic [31:0] addr; bit busy, valid; logic [31:0] hpc, hdata;
   } vec_t;
   vec_t tbl[9];

   // ---------------- reference model ----------------
   typedef struct { bit err; logic [31:0] pc; logic [31:0] data; } ent_t;
   ent_t        q[$];
   logic [31:0] m_pc;
   bit          m_pend, m_disc, m_halt, m_rerr, m_both;
   int          m_cnt;
   logic [31:0] m_rdat;
   int          lat_lo = 2, lat_hi = 2, err_pct = 0;
   logic [31:0] err_addr = 32'h1;
   logic [31:0] re_log[$];

   function automatic logic [31:0] re_at(input int i);
      return (re_log.size() > i) ? re_log[i] : 32'hDEAD_BEEF;
   endfunction

   task automatic model_reset();
      q.delete();
      re_log.delete();
      m_pc = 32'h0; m_pend = 0; m_disc = 0; m_halt = 0; m_rerr = 0; m_cnt = 0;
   endtask

   task automatic idle_inputs();
      enable_i = 0; redirect_i = 0; redirect_pc_i = '0; ipb_pop_i = 0;
      cache_ack_i = 0; cache_err_i = 0; cache_rdata_i = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      @(negedge clk) rstn = 0;
      @(negedge clk) rstn = 1;
      model_reset();
      @(posedge clk); #1;
   endtask

   // One clock cycle: drive inputs (i-cache responder included), check, advance model.
   task automatic cyc(input bit en, input bit red, input logic [31:0] rpc, input bit pop);
      bit ack_now, exp_re, popped, re_seen;
      int n;
      ent_t e;
      ack_now = 0;
      if (m_pend) begin
         if (m_cnt > 0) m_cnt--;
         ack_now = (m_cnt == 0);
      end
      enable_i = en; redirect_i = red; redirect_pc_i = rpc; ipb_pop_i = pop;
      cache_ack_i   = ack_now && (!m_rerr || m_both);
      cache_err_i   = ack_now && m_rerr;
      cache_rdata_i = ack_now ? m_rdat : $urandom();
      #1;
      n = q.size();
      popped = pop && (n > 0);
      if (red || m_halt) exp_re = 0;
      else if (!m_pend) exp_re = en && (n < DEPTH);
      else if (ack_now && !m_disc && !m_rerr) exp_re = en && ((n + 1 - int'(popped)) < DEPTH);
      else exp_re = 0;
      chk("re", 32'(cache_re_o), 32'(exp_re));
      chk("addr", cache_addr_o, m_pc);
      chk("busy", 32'(busy_o), 32'(m_pend));
      chk("valid", 32'(ipb_valid_o), 32'(n > 0));
      if (n > 0) begin
         chk("head_pc", ipb_pc_o, q[0].pc);
         chk("head_data", ipb_rdata_o, q[0].data);
         chk("head_err", 32'(ipb_err_o), 32'(q[0].err));
      end
      re_seen = cache_re_o;
      if (red) begin
         q.delete();
         m_halt = 0;
         m_disc = m_pend && !ack_now;
         m_pc = {rpc[31:2], 2'b00};
      end else begin
         if (popped) void'(q.pop_front());
         if (ack_now && !m_disc) begin
            e.err = m_rerr; e.pc = m_pc; e.data = m_rdat;
            q.push_back(e);
            m_pc = m_pc + 32'd4;
            if (m_rerr) m_halt = 1;
         end
         if (ack_now) m_disc = 0;
      end
      if (ack_now) m_pend = 0;
      if (exp_re) begin
         m_pend = 1;
         m_cnt  = $urandom_range(lat_hi, lat_lo);
         m_rdat = $urandom();
         m_rerr = (m_pc == err_addr) || ($urandom_range(99, 0) < err_pct);
         m_both = ($urandom_range(1, 0) == 1);
      end
      @(posedge clk); #1;
      // request address is the one held while the request is outstanding
      if (re_seen) re_log.push_back(cache_addr_o);
   endtask

   initial begin
      rstn = 0;
      idle_inputs();
      enable_i = 1;
      #2;
      chk("rst_re", 32'(cache_re_o), 32'h0);
      chk("rst_addr", cache_addr_o, 32'h0);
      chk("rst_busy", 32'(busy_o), 32'h0);
      chk("rst_valid", 32'(ipb_valid_o), 32'h0);
      chk("rst_rdata", ipb_rdata_o, 32'h0);
      chk("rst_pc", ipb_pc_o, 32'h0);
      chk("rst_err", 32'(ipb_err_o), 32'h0);
      @(negedge clk);
      enable_i = 0; rstn = 1;
      @(posedge clk); #1;

      // same-cycle redirect+ack drops the response; 0x103 fetches from 0x100
      tbl[0] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b1, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0};
      tbl[1] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h0};
      tbl[2] = '{1'b1, 1'b1, 32'h103, 1'b0, 1'b1, 32'hDEAD_0001, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h0};
      tbl[3] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   32'h0};
      tbl[4] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 32'h100, 1'b1, 1'b0, 32'h0,   32'h0};
      tbl[5] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h1111_2222, 1'b0, 32'h100, 1'b1, 1'b0, 32'h0,   32'h0};
      tbl[6] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 32'h104, 1'b0, 1'b1, 32'h100, 32'h1111_2222};
      tbl[7] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 32'h104, 1'b0, 1'b1, 32'h100, 32'h1111_2222};
      tbl[8] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 32'h104, 1'b0, 1'b0, 32'h0,   32'h0};
      for (int i = 0; i < 9; i++) begin
         enable_i = tbl[i].en; redirect_i = tbl[i].red; redirect_pc_i = tbl[i].rpc;
         ipb_pop_i = tbl[i].pop; cache_ack_i = tbl[i].ack; cache_err_i = 0;
         cache_rdata_i = tbl[i].data;
         #1;
         chk($sformatf("tbl%0d_re", i), 32'(cache_re_o), 32'(tbl[i].re));
         chk($sformatf("tbl%0d_addr", i), cache_addr_o, tbl[i].addr);
         chk($sformatf("tbl%0d_busy", i), 32'(busy_o), 32'(tbl[i].busy));
         chk($sformatf("tbl%0d_valid", i), 32'(ipb_valid_o), 32'(tbl[i].valid));
         if (tbl[i].valid) begin
            chk($sformatf("tbl%0d_hpc", i), ipb_pc_o, tbl[i].hpc);
            chk($sformatf("tbl%0d_hdata", i), ipb_rdata_o, tbl[i].hdata);
         end
         @(posedge clk); #1;
      end

      // fill to full with hits, then one pop releases the 5th request at 0x10
      do_reset();
      lat_lo = 2; lat_hi = 2;
      for (int i = 0; i < 12; i++) cyc(1, 0, 32'h0, 0);
      chk("s1_req_count", 32'(re_log.size()), 32'd4);
      chk("s1_full_valid", 32'(ipb_valid_o), 32'h1);
      re_log.delete();
      cyc(1, 0, 32'h0, 1);
      cyc(1, 0, 32'h0, 0);
      cyc(1, 0, 32'h0, 0);
      chk("s1_fifth_addr", re_at(0), 32'h10);

      // redirect while pending, ack 3 cycles later is discarded
      do_reset();
      lat_lo = 5; lat_hi = 5;
      cyc(1, 0, 32'h0, 0);
      cyc(1, 0, 32'h0, 0);
      lat_lo = 2; lat_hi = 2;
      re_log.delete();
      cyc(1, 1, 32'h80, 0);
      for (int i = 0; i < 3; i++) cyc(1, 0, 32'h0, 0);
      chk("s2_empty_after_drain", 32'(ipb_valid_o), 32'h0);
      for (int i = 0; i < 6; i++) cyc(1, 0, 32'h0, 0);
      chk("s2_first_req", re_at(0), 32'h80);
      chk("s2_head_pc", ipb_pc_o, 32'h80);

      // bus error at 0x20 halts fetching until a redirect
      do_reset();
      err_addr = 32'h20;
      cyc(1, 1, 32'h18, 0);
      for (int i = 0; i < 12; i++) cyc(1, 0, 32'h0, 0);
      chk("s4_req_count", 32'(re_log.size()), 32'd3);
      cyc(1, 0, 32'h0, 1);
      cyc(1, 0, 32'h0, 1);
      chk("s4_err_flag", 32'(ipb_err_o), 32'h1);
      chk("s4_err_pc", ipb_pc_o, 32'h20);
      err_addr = 32'h1;
      re_log.delete();
      cyc(1, 1, 32'h40, 0);
      cyc(1, 0, 32'h0, 0);
      cyc(1, 0, 32'h0, 0);
      chk("s4_resume", re_at(0), 32'h40);

      // concurrent push and pop at steady occupancy
      do_reset();
      for (int i = 0; i < 5; i++) cyc(1, 0, 32'h0, 0);
      for (int i = 0; i < 8; i++) cyc(1, 0, 32'h0, 1);

      // PC wrap at the top of the address space
      do_reset();
      re_log.delete();
      cyc(1, 1, 32'hFFFF_FFFC, 0);
      for (int i = 0; i < 6; i++) cyc(1, 0, 32'h0, 1);
      chk("s6_wrap_first", re_at(0), 32'hFFFF_FFFC);
      chk("s6_wrap_next", re_at(1), 32'h0);

      // asynchronous reset while a request is pending
      do_reset();
      for (int i = 0; i < 5; i++) cyc(1, 0, 32'h0, 0);
      cache_ack_i = 0; cache_err_i = 0;
      #2 rstn = 0;
      #1;
      chk("arst_re", 32'(cache_re_o), 32'h0);
      chk("arst_addr", cache_addr_o, 32'h0);
      chk("arst_busy", 32'(busy_o), 32'h0);
      chk("arst_valid", 32'(ipb_valid_o), 32'h0);
      chk("arst_pc", ipb_pc_o, 32'h0);
      chk("arst_rdata", ipb_rdata_o, 32'h0);
      chk("arst_err", 32'(ipb_err_o), 32'h0);
      idle_inputs();
      @(negedge clk) rstn = 1;
      model_reset();
      @(posedge clk); #1;

      // randomized traffic
      lat_lo = 2; lat_hi = 4; err_pct = 3;
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(9, 0) < 8), ($urandom_range(39, 0) == 0), $urandom(),
             ($urandom_range(1, 0) == 1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
